huff_share_ctrl: RTL and testbench

//  Shares one huff_encoder between NREQ requester streams.

---
 rtl/huff_pkg.sv | 26 ++
 rtl/huff_rr_arb.sv | 30 +++
 rtl/huff_share_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_huff_share_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pkg.sv
// Shared constants for the huff_share_ctrl slice: FSM encodings, map beat kinds,
// encoder flag patterns and the default symbol width.
package huff_pkg;

  // Default symbol width (BIT_WIDTH+1 for the stock encoder).
  localparam int SW = 8;

  // Controller states.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FEED = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_LEN  = 3'd3;
  localparam logic [2:0] ST_CODE = 3'd4;
  localparam logic [2:0] ST_SYM  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  // map_kind values.
  localparam logic [1:0] KIND_LEN  = 2'b01;
  localparam logic [1:0] KIND_CODE = 2'b10;
  localparam logic [1:0] KIND_SYM  = 2'b11;

  // {data_recv, code_map_recv} patterns from the encoder.
  localparam logic [1:0] FLAGS_LEN = 2'b10;
  localparam logic [1:0] FLAGS_MAP = 2'b01;

endpackage

// File: rtl/huff_rr_arb.sv
// Round-robin priority pick: first asserted request at or above ptr, wrapping
// modulo NREQ. Purely combinational.
module huff_rr_arb #(
  parameter int NREQ = 2,
  parameter int OW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [OW-1:0]   gnt_idx
);

  int j;

  // Walk NREQ slots starting at ptr; the first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = OW'(j);
      end
    end
  end

endmodule

// File: rtl/huff_share_ctrl.sv
// Shares one huff_encoder between NREQ requesters, one whole block at a time.
// Handshake: a requester symbol moves when req_valid[i] & req_ready[i] are both
// high at a clock edge; req_ready is only ever high for the owner during FEED.
// map_* beats are one-cycle pulses with no backpressure.
module huff_share_ctrl
  import huff_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int BIT_WIDTH  = SW - 1,
  parameter int NO_OF_DATA = 100,
  parameter int WDOG       = 4096,
  localparam int OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*(BIT_WIDTH+1)-1:0] req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic [BIT_WIDTH:0]          enc_data_in,
  output logic                        enc_data_enable,
  input  logic [2*BIT_WIDTH+2:0]      enc_data_out,
  input  logic                        enc_data_recv,
  input  logic                        enc_code_map_recv,
  output logic                        map_valid,
  output logic [1:0]                  map_kind,
  output logic [2*BIT_WIDTH+2:0]      map_data,
  output logic [BIT_WIDTH+1:0]        map_index,
  output logic [OW-1:0]               owner,
  output logic                        busy,
  output logic                        blk_done,
  output logic                        wdog_err,
  output logic [2:0]                  state_dbg
);

  localparam int SYM_W = BIT_WIDTH + 1;
  localparam int CW    = SYM_W + 1;
  localparam int DW    = 2 * BIT_WIDTH + 3;
  localparam int WW    = $clog2(WDOG + 1);

  logic [2:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] nsym_q, nsym_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          map_valid_q, map_valid_d;
  logic [1:0]    map_kind_q, map_kind_d;
  logic [DW-1:0] map_data_q, map_data_d;
  logic [CW-1:0] map_index_q, map_index_d;
  logic          blk_done_q, blk_done_d;
  logic          wdog_err_q, wdog_err_d;

  logic             gnt_valid;
  logic [OW-1:0]    gnt_idx;
  logic             sel_valid;
  logic [SYM_W-1:0] sel_data;
  logic [1:0]       flags;

  assign flags = {enc_data_recv, enc_code_map_recv};

  huff_rr_arb #(.NREQ(NREQ), .OW(OW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Route the owner's stream to the encoder while feeding.
  always_comb begin
    sel_valid       = 1'b0;
    sel_data        = '0;
    req_ready       = '0;
    enc_data_enable = 1'b0;
    enc_data_in     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*SYM_W +: SYM_W];
        if (state_q == ST_FEED) req_ready[i] = 1'b1;
      end
    end
    if (state_q == ST_FEED) begin
      enc_data_enable = sel_valid;
      enc_data_in     = sel_data;
    end
  end

  // Grant, feed counting, code-map phase tracking and watchdog.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    nsym_d      = nsym_q;
    idx_d       = idx_q;
    wdog_d      = '0;
    map_valid_d = 1'b0;
    map_kind_d  = map_kind_q;
    map_data_d  = map_data_q;
    map_index_d = map_index_q;
    blk_done_d  = 1'b0;
    wdog_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          cnt_d   = '0;
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        if (sel_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NO_OF_DATA - 1)) begin
            nsym_d  = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flags == FLAGS_LEN) begin
          map_valid_d = 1'b1;
          map_kind_d  = KIND_LEN;
          map_data_d  = enc_data_out;
          map_index_d = '0;
          nsym_d      = CW'(1);
          state_d     = ST_LEN;
        end else if (wdog_q == WW'(WDOG - 1)) begin
          wdog_err_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ST_LEN: begin
        if (flags == FLAGS_LEN) begin
          map_valid_d = 1'b1;
          map_kind_d  = KIND_LEN;
          map_data_d  = enc_data_out;
          map_index_d = nsym_q;
          nsym_d      = nsym_q + CW'(1);
        end else if (flags == FLAGS_MAP) begin
          // This cycle already carries code 0; a one-symbol map has no more codes.
          map_valid_d = 1'b1;
          map_kind_d  = KIND_CODE;
          map_data_d  = enc_data_out;
          map_index_d = '0;
          if (nsym_q == CW'(1)) begin
            idx_d   = '0;
            state_d = ST_SYM;
          end else begin
            idx_d   = CW'(1);
            state_d = ST_CODE;
          end
        end
      end
      ST_CODE: begin
        map_valid_d = 1'b1;
        map_kind_d  = KIND_CODE;
        map_data_d  = enc_data_out;
        map_index_d = idx_q;
        if (flags != FLAGS_MAP) wdog_err_d = 1'b1;
        if (idx_q == nsym_q - CW'(1)) begin
          idx_d   = '0;
          state_d = ST_SYM;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      ST_SYM: begin
        map_valid_d = 1'b1;
        map_kind_d  = KIND_SYM;
        map_data_d  = enc_data_out;
        map_index_d = idx_q;
        if (idx_q == nsym_q - CW'(1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      ST_DONE: begin
        blk_done_d = 1'b1;
        rr_d       = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any block in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      nsym_q      <= '0;
      idx_q       <= '0;
      wdog_q      <= '0;
      map_valid_q <= 1'b0;
      map_kind_q  <= '0;
      map_data_q  <= '0;
      map_index_q <= '0;
      blk_done_q  <= 1'b0;
      wdog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      nsym_q      <= nsym_d;
      idx_q       <= idx_d;
      wdog_q      <= wdog_d;
      map_valid_q <= map_valid_d;
      map_kind_q  <= map_kind_d;
      map_data_q  <= map_data_d;
      map_index_q <= map_index_d;
      blk_done_q  <= blk_done_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  assign map_valid = map_valid_q;
  assign map_kind  = map_kind_q;
  assign map_data  = map_data_q;
  assign map_index = map_index_q;
  assign owner     = owner_q;
  assign busy      = (state_q != ST_IDLE);
  assign blk_done  = blk_done_q;
  assign wdog_err  = wdog_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_huff_share_ctrl.sv
// Directed bench for huff_share_ctrl with a hand-driven encoder model and a
// scoreboard of expected map beats {kind, index, data}.
module tb_huff_share_ctrl;
  import huff_pkg::*;

  localparam int NR = 2;
  localparam int BW = 7;
  localparam int ND = 100;
  localparam int WD = 32;

  logic          clock;
  logic          reset_n;
  logic [1:0]    req_valid;
  logic [15:0]   req_data;
  logic [1:0]    req_ready;
  logic [7:0]    enc_data_in;
  logic          enc_data_enable;
  logic [16:0]   enc_data_out;
  logic          enc_data_recv;
  logic          enc_code_map_recv;
  logic          map_valid;
  logic [1:0]    map_kind;
  logic [16:0]   map_data;
  logic [8:0]    map_index;
  logic [0:0]    owner;
  logic          busy;
  logic          blk_done;
  logic          wdog_err;
  logic [2:0]    state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [27:0] exp_q[$];
  logic [16:0] mdl_len[0:3];
  logic [16:0] mdl_code[0:3];
  logic [16:0] mdl_sym[0:3];

  huff_share_ctrl #(.NREQ(NR), .BIT_WIDTH(BW), .NO_OF_DATA(ND), .WDOG(WD)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .enc_data_in       (enc_data_in),
    .enc_data_enable   (enc_data_enable),
    .enc_data_out      (enc_data_out),
    .enc_data_recv     (enc_data_recv),
    .enc_code_map_recv (enc_code_map_recv),
    .map_valid         (map_valid),
    .map_kind          (map_kind),
    .map_data          (map_data),
    .map_index         (map_index),
    .owner             (owner),
    .busy              (busy),
    .blk_done          (blk_done),
    .wdog_err          (wdog_err),
    .state_dbg         (state_dbg)
  );

  // Clock and global time limit.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every map beat must match the head of the expected queue.
  always @(negedge clock) begin
    if (map_valid) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL map_extra: observed beat %0h expected none", {map_kind, map_index, map_data});
      end
      if (exp_q.size() != 0) check("map_beat", {4'h0, map_kind, map_index, map_data}, {4'h0, exp_q.pop_front()});
    end
  end

  // Requester driver: offers symbols until n_xfer handshakes, checking the feed.
  task automatic feed_block(input int who, input logic [7:0] val, input bit gaps, input int n_xfer);
    int sent, en_cnt, cyc;
    bit started;
    sent = 0; en_cnt = 0; cyc = 0; started = 0;
    while (sent < n_xfer && cyc < 4000) begin
      req_valid[who] = gaps ? ((cyc % 2) == 0) : 1'b1;
      req_data[who*8 +: 8] = val;
      #1;
      if (started) begin
        check("feed_state", {29'd0, state_dbg}, {29'd0, ST_FEED});
        check("other_ready", {31'd0, req_ready[1-who]}, 32'd0);
      end
      if (enc_data_enable) en_cnt++;
      if (req_valid[who] && req_ready[who]) begin
        if (!started) check("grant_owner", {31'd0, owner}, who);
        started = 1;
        sent++;
        check("enc_data_in", {24'd0, enc_data_in}, {24'd0, val});
      end
      @(negedge clock);
      cyc++;
    end
    req_valid[who] = 1'b0;
    check("xfer_count", sent, n_xfer);
    check("enable_count", en_cnt, n_xfer);
    if (n_xfer == ND) check("wait_map", {29'd0, state_dbg}, {29'd0, ST_WAIT});
  endtask

  // Encoder model: idle/ignored flags, then n lengths, n codes, n symbols.
  task automatic drive_map(input int n);
    {enc_data_recv, enc_code_map_recv} = 2'b00;
    enc_data_out = '0;
    repeat (2) @(negedge clock);
    {enc_data_recv, enc_code_map_recv} = 2'b11;
    @(negedge clock);
    for (int i = 0; i < n; i++) begin
      {enc_data_recv, enc_code_map_recv} = 2'b10;
      enc_data_out = mdl_len[i];
      exp_q.push_back({KIND_LEN, 9'(i), mdl_len[i]});
      @(negedge clock);
    end
    for (int i = 0; i < n; i++) begin
      {enc_data_recv, enc_code_map_recv} = 2'b01;
      enc_data_out = mdl_code[i];
      exp_q.push_back({KIND_CODE, 9'(i), mdl_code[i]});
      @(negedge clock);
    end
    for (int i = 0; i < n; i++) begin
      {enc_data_recv, enc_code_map_recv} = 2'b01;
      enc_data_out = mdl_sym[i];
      exp_q.push_back({KIND_SYM, 9'(i), mdl_sym[i]});
      @(negedge clock);
    end
    {enc_data_recv, enc_code_map_recv} = 2'b00;
    enc_data_out = '0;
  endtask

  // Bounded wait for blk_done, then check release and pulse width.
  task automatic wait_done(input int exp_owner);
    bit seen;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (blk_done) seen = 1;
    end
    check("blk_done_seen", {31'd0, seen}, 32'd1);
    check("map_drained", exp_q.size(), 32'd0);
    check("done_owner", {31'd0, owner}, exp_owner);
    check("done_idle", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("done_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("blk_done_pulse", {31'd0, blk_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_owner"}, {31'd0, owner}, 32'd0);
    check({tag, "_ready"}, {30'd0, req_ready}, 32'd0);
    check({tag, "_enable"}, {31'd0, enc_data_enable}, 32'd0);
    check({tag, "_enc_in"}, {24'd0, enc_data_in}, 32'd0);
    check({tag, "_map_valid"}, {31'd0, map_valid}, 32'd0);
    check({tag, "_map_kind"}, {30'd0, map_kind}, 32'd0);
    check({tag, "_map_index"}, {23'd0, map_index}, 32'd0);
    check({tag, "_map_data"}, {15'd0, map_data}, 32'd0);
    check({tag, "_blk_done"}, {31'd0, blk_done}, 32'd0);
    check({tag, "_wdog_err"}, {31'd0, wdog_err}, 32'd0);
  endtask

  initial begin
    int first_err, first_done, n_err_pulses;
    reset_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    enc_data_out = '0;
    enc_data_recv = 1'b0;
    enc_code_map_recv = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Both requesters valid from reset: req0 (value 5) wins, 1-beat map.
    mdl_len[0] = 17'h00001; mdl_code[0] = 17'h00000; mdl_sym[0] = 17'h00005;
    req_valid = 2'b11;
    req_data[15:8] = 8'h11;
    feed_block(0, 8'h05, 1'b0, ND);
    drive_map(1);
    wait_done(0);

    // req1 follows, dropping valid every other cycle; 3-symbol map, lengths 1,2,2.
    mdl_len[0] = 17'h00001; mdl_len[1] = 17'h00002; mdl_len[2] = 17'h00002;
    mdl_code[0] = 17'h00000; mdl_code[1] = 17'h00002; mdl_code[2] = 17'h00003;
    mdl_sym[0] = 17'h00041; mdl_sym[1] = 17'h00042; mdl_sym[2] = 17'h00043;
    feed_block(1, 8'h11, 1'b1, ND);
    drive_map(3);
    wait_done(1);

    // Fresh contention: pointer is back at 0, so req0 wins again; then stall.
    req_valid = 2'b11;
    feed_block(0, 8'h33, 1'b0, ND);
    req_valid[1] = 1'b0;
    {enc_data_recv, enc_code_map_recv} = 2'b11;
    first_err = 0; first_done = 0; n_err_pulses = 0;
    for (int k = 1; k <= WD + 4; k++) begin
      @(negedge clock);
      if (wdog_err) begin
        n_err_pulses++;
        if (first_err == 0) first_err = k;
      end
      if (blk_done && first_done == 0) first_done = k;
      if (k == WD + 1) check("wdog_idle", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    end
    {enc_data_recv, enc_code_map_recv} = 2'b00;
    check("wdog_cycle", first_err, WD);
    check("wdog_pulses", n_err_pulses, 32'd1);
    check("wdog_blk_done", first_done, WD + 1);

    // req1 granted (pointer 1), reset after 40 transfers, then a full block.
    feed_block(1, 8'h5A, 1'b0, 40);
    check("mid_owner", {31'd0, owner}, 32'd1);
    req_valid[1] = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    mdl_len[0] = 17'h00001; mdl_code[0] = 17'h00001; mdl_sym[0] = 17'h000A7;
    feed_block(1, 8'hA7, 1'b0, ND);
    drive_map(1);
    wait_done(1);

    check("final_queue", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
